// File: rtl/ps2_pkg.sv
// Shared constants, FSM state type and frame helpers for the PS/2 receive path.
package ps2_pkg;

    // Prefix bytes folded into the brk/ext flags.
    localparam logic [7:0] PS2_BRK = 8'hF0;
    localparam logic [7:0] PS2_EXT = 8'hE0;

    // Bit positions inside the captured frame (start bit is not stored).
    localparam int unsigned FRAME_BITS     = 10;
    localparam int unsigned FRAME_DATA_LSB = 0;
    localparam int unsigned FRAME_DATA_MSB = 7;
    localparam int unsigned FRAME_PARITY   = 8;
    localparam int unsigned FRAME_STOP     = 9;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StCheck
    } ps2_state_e;

    // Odd parity over data+parity, and a high stop bit.
    function automatic logic frame_ok(input logic [FRAME_BITS-1:0] f);
        return ((^f[FRAME_DATA_MSB:FRAME_DATA_LSB]) ^ f[FRAME_PARITY]) & f[FRAME_STOP];
    endfunction

endpackage

// File: rtl/ps2_edge_filter.sv
// Synchroniser, glitch filter and falling-edge detector for the PS/2 clock pin.
module ps2_edge_filter
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 8
) (
    input  logic clkin,
    input  logic rst,
    input  logic pin_i,
    output logic fe_o
);

    localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   kf_q, kf_d;
    logic                   kf_dly_q, kf_dly_d;
    logic                   fe_q, fe_d;
    logic                   samp;

    assign samp = sync_q[SYNC_STAGES-1];
    assign fe_o = fe_q;

    // Shift the raw pin through the synchroniser chain.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = pin_i;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Count consecutive samples that disagree with kf; flip kf once enough have been seen.
    always_comb begin
        cnt_d    = cnt_q;
        kf_d     = kf_q;
        kf_dly_d = kf_q;
        if (samp == kf_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntLast) begin
            kf_d  = samp;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
        // Registered one cycle after kf falls so fe lands SYNC+FILTER+1 cycles after the pin.
        fe_d = kf_dly_q & ~kf_q;
    end

    // State registers; everything presets to the idle (high) line level.
    always_ff @(posedge clkin) begin
        if (!rst) begin
            sync_q   <= '1;
            cnt_q    <= '0;
            kf_q     <= 1'b1;
            kf_dly_q <= 1'b1;
            fe_q     <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            kf_q     <= kf_d;
            kf_dly_q <= kf_dly_d;
            fe_q     <= fe_d;
        end
    end

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 keyboard frame receiver: shifts in 11-bit frames, checks them, folds F0/E0 prefixes.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       kbclk,
    input  logic       kbdata,
    output logic [7:0] code,
    output logic       code_vld,
    output logic       brk,
    output logic       ext,
    output logic       err,
    output logic       busy
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CYC);

    logic                   fe;
    logic [SYNC_STAGES-1:0] dsync_q, dsync_d;
    logic                   data_s;

    ps2_state_e             state_q, state_d;
    logic [3:0]             bitcnt_q, bitcnt_d;
    logic [FRAME_BITS-1:0]  frame_q, frame_d;
    logic [TmoW-1:0]        tmo_q, tmo_d;
    logic                   brk_pend_q, brk_pend_d;
    logic                   ext_pend_q, ext_pend_d;
    logic [7:0]             code_q, code_d;
    logic                   brk_q, brk_d;
    logic                   ext_q, ext_d;
    logic                   code_vld_q, code_vld_d;
    logic                   err_q, err_d;
    logic [7:0]             frame_data;

    ps2_edge_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_clk_filt (
        .clkin (clkin),
        .rst   (rst),
        .pin_i (kbclk),
        .fe_o  (fe)
    );

    assign data_s     = dsync_q[SYNC_STAGES-1];
    assign frame_data = frame_q[FRAME_DATA_MSB:FRAME_DATA_LSB];

    assign code     = code_q;
    assign code_vld = code_vld_q;
    assign brk      = brk_q;
    assign ext      = ext_q;
    assign err      = err_q;
    assign busy     = (state_q != StIdle);

    // Data pin only needs synchronising; it is stable while the clock is low.
    always_comb begin
        dsync_d    = dsync_q;
        dsync_d[0] = kbdata;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            dsync_d[i] = dsync_q[i-1];
        end
    end

    // Frame FSM: next state, shift register, timeout and decoded outputs.
    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        frame_d    = frame_q;
        tmo_d      = tmo_q;
        brk_pend_d = brk_pend_q;
        ext_pend_d = ext_pend_q;
        code_d     = code_q;
        brk_d      = brk_q;
        ext_d      = ext_q;
        code_vld_d = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                tmo_d    = '0;
                bitcnt_d = '0;
                if (fe) begin
                    if (!data_s) begin
                        state_d = StShift;
                    end else begin
                        // False start: line went low with data high.
                        err_d = 1'b1;
                    end
                end
            end

            StShift: begin
                // An fe in the same cycle as the timeout wins.
                if (fe) begin
                    for (int i = 0; i < FRAME_BITS; i++) begin
                        if (bitcnt_q == 4'(i)) begin
                            frame_d[i] = data_s;
                        end
                    end
                    bitcnt_d = bitcnt_q + 4'd1;
                    tmo_d    = '0;
                    if (bitcnt_q == 4'(FRAME_STOP)) begin
                        state_d = StCheck;
                    end
                end else if (tmo_q == TmoMax) begin
                    err_d      = 1'b1;
                    brk_pend_d = 1'b0;
                    ext_pend_d = 1'b0;
                    state_d    = StIdle;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end

            StCheck: begin
                state_d = StIdle;
                if (!frame_ok(frame_q)) begin
                    err_d      = 1'b1;
                    brk_pend_d = 1'b0;
                    ext_pend_d = 1'b0;
                end else if (frame_data == PS2_BRK) begin
                    brk_pend_d = 1'b1;
                end else if (frame_data == PS2_EXT) begin
                    ext_pend_d = 1'b1;
                end else begin
                    code_d     = frame_data;
                    brk_d      = brk_pend_q;
                    ext_d      = ext_pend_q;
                    code_vld_d = 1'b1;
                    brk_pend_d = 1'b0;
                    ext_pend_d = 1'b0;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clkin) begin
        if (!rst) begin
            dsync_q    <= '1;
            state_q    <= StIdle;
            bitcnt_q   <= '0;
            frame_q    <= '0;
            tmo_q      <= '0;
            brk_pend_q <= 1'b0;
            ext_pend_q <= 1'b0;
            code_q     <= '0;
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            code_vld_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            dsync_q    <= dsync_d;
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            frame_q    <= frame_d;
            tmo_q      <= tmo_d;
            brk_pend_q <= brk_pend_d;
            ext_pend_q <= ext_pend_d;
            code_q     <= code_d;
            brk_q      <= brk_d;
            ext_q      <= ext_d;
            code_vld_q <= code_vld_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed + randomised bench for ps2_rx_frame with a byte-level reference model.
module tb_ps2_rx_frame;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned FILTER_LEN  = 8;
    localparam int unsigned TIMEOUT_CYC = 2000;
    localparam int          HALF        = 30;
    localparam int          GAP         = 20;
    localparam int          LAT         = SYNC_STAGES + FILTER_LEN + 3;

    logic       clkin  = 1'b0;
    logic       rst    = 1'b0;
    logic       kbclk  = 1'b1;
    logic       kbdata = 1'b1;
    logic [7:0] code;
    logic       code_vld;
    logic       brk;
    logic       ext;
    logic       err;
    logic       busy;

    ps2_rx_frame #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clkin    (clkin),
        .rst      (rst),
        .kbclk    (kbclk),
        .kbdata   (kbdata),
        .code     (code),
        .code_vld (code_vld),
        .brk      (brk),
        .ext      (ext),
        .err      (err),
        .busy     (busy)
    );

    always #5 clkin = ~clkin;

    int cyc      = 0;
    int vld_cnt  = 0;
    int err_cnt  = 0;
    int busy_cyc = 0;
    int vld_cyc  = 0;
    int err_cyc  = 0;
    int fall_cyc = 0;
    int n_cmp    = 0;
    int n_bad    = 0;

    // Reference model state: pending prefixes and the last delivered event.
    logic [7:0] m_code     = 8'h00;
    logic       m_brk      = 1'b0;
    logic       m_ext      = 1'b0;
    logic       m_brk_pend = 1'b0;
    logic       m_ext_pend = 1'b0;

    always @(posedge clkin) cyc <= cyc + 1;

    // Pulse/level monitor sampled mid-cycle.
    always @(negedge clkin) begin
        if (code_vld === 1'b1) begin
            vld_cnt <= vld_cnt + 1;
            vld_cyc <= cyc;
        end
        if (err === 1'b1) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
        if (busy === 1'b1) busy_cyc <= busy_cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Bits go out LSB first; data changes while the clock is high.
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            kbdata = bits[i];
            repeat (HALF) @(negedge clkin);
            kbclk    = 1'b0;
            fall_cyc = cyc;
            repeat (HALF) @(negedge clkin);
            kbclk = 1'b1;
        end
        kbdata = 1'b1;
    endtask

    task automatic do_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop,
                            input string tag);
        logic [10:0] bits;
        int          v0, e0;
        logic        exp_vld, exp_err;
        bits    = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
        v0      = vld_cnt;
        e0      = err_cnt;
        exp_vld = 1'b0;
        exp_err = 1'b0;
        if (bad_par || bad_stop) begin
            exp_err    = 1'b1;
            m_brk_pend = 1'b0;
            m_ext_pend = 1'b0;
        end else if (d == 8'hF0) begin
            m_brk_pend = 1'b1;
        end else if (d == 8'hE0) begin
            m_ext_pend = 1'b1;
        end else begin
            exp_vld    = 1'b1;
            m_code     = d;
            m_brk      = m_brk_pend;
            m_ext      = m_ext_pend;
            m_brk_pend = 1'b0;
            m_ext_pend = 1'b0;
        end
        send_bits(bits, 11);
        repeat (GAP) @(negedge clkin);
        chk($sformatf("%s.vld_pulses", tag), 32'(vld_cnt - v0), 32'(exp_vld));
        chk($sformatf("%s.err_pulses", tag), 32'(err_cnt - e0), 32'(exp_err));
        chk($sformatf("%s.code", tag), 32'(code), 32'(m_code));
        chk($sformatf("%s.brk", tag), 32'(brk), 32'(m_brk));
        chk($sformatf("%s.ext", tag), 32'(ext), 32'(m_ext));
        if (exp_vld) chk($sformatf("%s.vld_lat", tag), 32'(vld_cyc - fall_cyc), 32'(LAT));
        if (exp_err) chk($sformatf("%s.err_lat", tag), 32'(err_cyc - fall_cyc), 32'(LAT));
    endtask

    task automatic model_reset();
        m_code     = 8'h00;
        m_brk      = 1'b0;
        m_ext      = 1'b0;
        m_brk_pend = 1'b0;
        m_ext_pend = 1'b0;
    endtask

    initial begin
        int          e0, b0, r, e;
        logic [7:0]  d;

        // Reset state.
        rst = 1'b0;
        repeat (5) @(negedge clkin);
        chk("rst.code", 32'(code), 32'h0);
        chk("rst.code_vld", 32'(code_vld), 32'h0);
        chk("rst.brk", 32'(brk), 32'h0);
        chk("rst.ext", 32'(ext), 32'h0);
        chk("rst.err", 32'(err), 32'h0);
        chk("rst.busy", 32'(busy), 32'h0);
        rst = 1'b1;
        repeat (10) @(negedge clkin);

        // Plain make code, break sequence, extended break, then bare code.
        do_frame(8'h16, 1'b0, 1'b0, "make16");
        do_frame(8'hF0, 1'b0, 1'b0, "brkF0");
        do_frame(8'h16, 1'b0, 1'b0, "brk16");
        do_frame(8'hE0, 1'b0, 1'b0, "extE0");
        do_frame(8'hF0, 1'b0, 1'b0, "extF0");
        do_frame(8'h75, 1'b0, 1'b0, "ext75");
        do_frame(8'h75, 1'b0, 1'b0, "bare75");

        // Bad parity keeps the old code; the next good frame decodes.
        do_frame(8'h16, 1'b1, 1'b0, "badpar");
        do_frame(8'h16, 1'b0, 1'b0, "afterpar");
        do_frame(8'h2A, 1'b0, 1'b1, "badstop");

        // Timeout mid-frame, with a pending break that must be dropped.
        do_frame(8'hF0, 1'b0, 1'b0, "tmoF0");
        e0 = err_cnt;
        send_bits({2'b11, 8'h1C, 1'b0}, 5);
        chk("tmo.busy_mid", 32'(busy), 32'h1);
        repeat (TIMEOUT_CYC + 100) @(negedge clkin);
        chk("tmo.err_pulses", 32'(err_cnt - e0), 32'h1);
        chk("tmo.busy_after", 32'(busy), 32'h0);
        m_brk_pend = 1'b0;
        m_ext_pend = 1'b0;
        do_frame(8'h1C, 1'b0, 1'b0, "after_tmo");

        // FILTER_LEN-1 cycle glitch is swallowed.
        e0 = err_cnt;
        b0 = busy_cyc;
        kbdata = 1'b1;
        kbclk  = 1'b0;
        repeat (FILTER_LEN - 1) @(negedge clkin);
        kbclk = 1'b1;
        repeat (40) @(negedge clkin);
        chk("glitch7.err", 32'(err_cnt - e0), 32'h0);
        chk("glitch7.busy", 32'(busy_cyc - b0), 32'h0);

        // FILTER_LEN cycles low passes the filter and reads as a false start.
        e0 = err_cnt;
        kbclk = 1'b0;
        repeat (FILTER_LEN) @(negedge clkin);
        kbclk = 1'b1;
        repeat (40) @(negedge clkin);
        chk("glitch8.err", 32'(err_cnt - e0), 32'h1);
        chk("glitch8.busy", 32'(busy_cyc - b0), 32'h0);

        // Reset mid-frame discards everything.
        do_frame(8'hE0, 1'b0, 1'b0, "preRstE0");
        send_bits({2'b11, 8'h5A, 1'b0}, 5);
        rst = 1'b0;
        @(negedge clkin);
        chk("midrst.code", 32'(code), 32'h0);
        chk("midrst.code_vld", 32'(code_vld), 32'h0);
        chk("midrst.brk", 32'(brk), 32'h0);
        chk("midrst.ext", 32'(ext), 32'h0);
        chk("midrst.err", 32'(err), 32'h0);
        chk("midrst.busy", 32'(busy), 32'h0);
        rst = 1'b1;
        model_reset();
        repeat (10) @(negedge clkin);
        do_frame(8'h5A, 1'b0, 1'b0, "postrst");

        // Random traffic with extra prefix bytes and occasional corrupt frames.
        for (int k = 0; k < 16; k++) begin
            r = int'($urandom_range(0, 9));
            e = int'($urandom_range(0, 9));
            if (r == 0) d = 8'hF0;
            else if (r == 1) d = 8'hE0;
            else d = 8'($urandom_range(0, 255));
            do_frame(d, e == 0, e == 1, $sformatf("rand%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_rx_frame.md
# ps2_rx_frame

PS/2 keyboard frame receiver that sits directly upstream of the scan-code-to-seven-segment decoder and the code-compare logic. It synchronises and de-glitches the raw `kbclk`/`kbdata` pins in the `clkin` domain and shifts in 11-bit frames. Each frame's start, odd parity and stop bits are checked. The block folds `F0` (break) and `E0` (extended) prefixes into flags and delivers one validated 8-bit make/break code per key event as a single-cycle strobe.

## Interface
Parameters:
- `SYNC_STAGES`, 2 — flip-flop synchroniser depth on both PS/2 pins.
- `FILTER_LEN`, 8 — consecutive identical synchronised `kbclk` samples needed before the filtered clock changes level.
- `TIMEOUT_CYC`, 100000 — `clkin` cycles allowed between two filtered `kbclk` falling edges inside a frame (2 ms at 50 MHz).

Ports:
- `clkin` in 1 — system clock; every register is in this domain.
- `rst` in 1 — reset, synchronous, active-low.
- `kbclk` in 1 — raw PS/2 clock pin, asynchronous.
- `kbdata` in 1 — raw PS/2 data pin, asynchronous.
- `code` out 8 — last valid scan code, prefix bytes stripped; holds until the next valid code.
- `code_vld` out 1 — one-cycle pulse when `code`, `brk` and `ext` update.
- `brk` out 1 — `code` was preceded by `F0`.
- `ext` out 1 — `code` was preceded by `E0`.
- `err` out 1 — one-cycle pulse on any of: bad start, bad parity, bad stop, or timeout.
- `busy` out 1 — high from the start bit until the frame completes or aborts.

## Operation
- Reset (`rst`=0 at a `clkin` edge):
  - `code`=0; `code_vld`, `brk`, `ext`, `err`, `busy` = 0.
  - FSM goes to IDLE; both prefix flags clear.
  - Synchroniser and filter preset to 1 (idle line level).
  - Reset applies identically mid-frame; any partial frame is discarded.
- Filtered clock `kf` toggles only after `FILTER_LEN` equal synchronised samples. The event `fe` is a one-cycle pulse on each 1→0 transition of `kf`.
- `kbdata` is synchronised only, not filtered, and is sampled on the `fe` cycle.
- FSM states IDLE, SHIFT, CHECK:
  - IDLE:
    - On `fe` with data=0: go to SHIFT, `bitcnt`=0, `busy`=1.
    - On `fe` with data=1: this is a false start. Pulse `err` and stay in IDLE.
  - SHIFT:
    - On each `fe`, store the sampled bit at index `bitcnt` of a 10-bit frame register: bits 0-7 data LSB-first, bit 8 parity, bit 9 stop. Then increment `bitcnt`.
    - After the `fe` that stores bit 9, go to CHECK.
    - Timeout counter: clears on each `fe`. If it reaches `TIMEOUT_CYC`, pulse `err`, drop `busy`, clear prefix flags and go to IDLE.
  - CHECK (exactly one cycle, then IDLE, `busy`=0):
    - Valid frame = (XOR of data[7:0] and parity == 1) and stop == 1.
    - Invalid frame: pulse `err`, clear both prefix flags; `code`, `brk` and `ext` are unchanged.
    - Valid with data=`F0`: set `brk_pend`; no strobe.
    - Valid with data=`E0`: set `ext_pend`; no strobe.
    - Valid with any other data: `code`=data, `brk`=`brk_pend`, `ext`=`ext_pend`, pulse `code_vld`, then clear both pending flags.
- `F0` arriving with `brk_pend` already set is accepted with no error; the flag stays set.
- Timeout counter width is `$clog2(TIMEOUT_CYC+1)`. It saturates and cannot wrap.

## Timing
- Pin to `fe`: `SYNC_STAGES` + `FILTER_LEN` + 1 cycles after the raw falling edge of `kbclk`.
- The stop-bit `fe` occurs in cycle N. CHECK is cycle N+1, and `code_vld`/`err` are registered high in cycle N+2 for exactly one cycle.
- `code`, `brk` and `ext` change in the same cycle `code_vld` rises.
- Pin-to-sample delay of (`SYNC_STAGES`+`FILTER_LEN`) cycles must stay well under the PS/2 clock-low time of 30 µs. The defaults give 200 ns at 50 MHz.
- `rst` overrides all other events in the same cycle. A timeout and an `fe` in the same cycle resolve in favour of `fe`, which is accepted and restarts the counter.

## Structure
- Package `ps2_pkg` holds:
  - constants `PS2_BRK`=8'hF0 and `PS2_EXT`=8'hE0;
  - the FSM state enum (IDLE/SHIFT/CHECK);
  - the frame bit-index constants: data 0-7, parity 8, stop 9.
- Sub-module `ps2_edge_filter`: synchroniser, glitch filter and falling-edge detector, parameterised by `SYNC_STAGES`/`FILTER_LEN`. It is instantiated for `kbclk`. `kbdata` uses a bare synchroniser.

## Test plan
- Frame `0x16` (data bits 0,1,1,0,1,0,0,0; parity 0; stop 1) → one `code_vld` pulse, `code`=0x16, `brk`=0, `ext`=0, `err` never asserts.
- Frames `F0`,`16` → exactly one `code_vld` pulse, on the second frame, with `code`=0x16 and `brk`=1.
- Frames `E0`,`F0`,`75` (parity 0) → one `code_vld` pulse with `code`=0x75, `ext`=1, `brk`=1. A following bare `75` frame gives `brk`=0, `ext`=0.
- `0x16` sent with parity 1 → one `err` pulse two cycles after the stop `fe`, no `code_vld`, `code` keeps its previous value. The next good frame decodes normally.
- Five bits sent, then `kbclk` held high for more than `TIMEOUT_CYC` → one `err` pulse and `busy` falls. A following full `0x1C` frame gives `code`=0x1C.
- A 7-cycle (`FILTER_LEN`-1) low glitch on `kbclk` in IDLE → no `fe`, no `busy`. `rst`=0 asserted mid-frame → all outputs 0 at the next edge, and a fresh frame after release decodes correctly.
